// File: rtl/mem_io_responder_pkg.sv
// mem_map_pkg: memory map shared by the memory-port responder and its timer.
//   Region codes decode addr[15:12]; timer offsets decode addr[0];
//   CTRL bit indices locate the clear and enable bits in a CTRL write.
package mem_map_pkg;

    localparam logic [3:0] REG_RAM = 4'h0;
    localparam logic [3:0] REG_LED = 4'h1;
    localparam logic [3:0] REG_TMR = 4'h2;
    localparam logic [3:0] REG_SW  = 4'h3;

    localparam logic TMR_LOAD = 1'b0;
    localparam logic TMR_CTRL = 1'b1;

    localparam int BIT_CLR = 0;
    localparam int BIT_EN  = 1;

endpackage

// File: rtl/mem_io_responder_if.sv
// mem_io_if: processor memory-port bundle.
//   addr  word address from the processor ADDR register
//   dout  write data from the processor DOUT register
//   w     write enable, active high
//   din   registered read data back to the processor
// The processor side uses the master modport, the responder the slave modport.
interface mem_io_if;

    logic [15:0] addr;
    logic [15:0] dout;
    logic        w;
    logic [15:0] din;

    modport master (output addr, output dout, output w, input din);
    modport slave  (input addr, input dout, input w, output din);

endinterface

// File: rtl/mem_io_responder_io_timer.sv
// io_timer: down-counting timer with prescaler, reload register, enable and
// a sticky expired flag.
//   clk, reset_n   clock and asynchronous active-low reset
//   load_we        LOAD write strobe: reload = count = wdata, prescaler cleared
//   ctrl_we        CTRL write strobe: en = wdata[BIT_EN], wdata[BIT_CLR] clears expired
//   wdata          write data from the processor
//   count          current count value
//   en             timer enable
//   expired        sticky expiry flag
// Only instantiated when MEM_IO_TIMER_EN is defined.
module io_timer
    import mem_map_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_we,
    input  logic        ctrl_we,
    input  logic [15:0] wdata,
    output logic [15:0] count,
    output logic        en,
    output logic        expired
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;
    logic [15:0]   reload;
    logic          tick;
    logic          expire;

    assign tick   = en && (presc == PRESC_LAST);
    assign expire = tick && (count == 16'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc   <= '0;
            reload  <= '0;
            count   <= '0;
            en      <= 1'b0;
            expired <= 1'b0;
        end else begin
            // A LOAD write takes priority over whatever the tick would do.
            if (load_we) begin
                presc  <= '0;
                reload <= wdata;
                count  <= wdata;
            end else if (en) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    count <= (count == 16'd0) ? reload : count - 16'd1;
                end
            end

            if (ctrl_we) begin
                en <= wdata[BIT_EN];
            end

            // Setting wins over a same-cycle clear so an expiry is never lost.
            if (expire) begin
                expired <= 1'b1;
            end else if (ctrl_we && wdata[BIT_CLR]) begin
                expired <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: responder on the processor memory port.
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      mem_io_if.slave: addr, dout, w in; registered din out (1-cycle latency)
//   sw       raw asynchronous board switches (SW_W bits)
//   ledr     LED register (SW_W bits)
//   irq      sticky timer-expired level
// Map on addr[15:12]: 0x0 RAM (aliased on addr[RAM_AW-1:0]), 0x1 LED,
// 0x2 timer, 0x3 switches; other regions read 0 and ignore writes.
// Build option: define MEM_IO_TIMER_EN to generate the timer; without it
// region 0x2 behaves as unmapped and irq is tied low.
module mem_io_responder
    import mem_map_pkg::*;
#(
    parameter int RAM_AW   = 8,
    parameter int SW_W     = 10,
    parameter int PRESCALE = 50000
) (
    input  logic            clk,
    input  logic            reset_n,
    mem_io_if.slave         bus,
    input  logic [SW_W-1:0] sw,
    output logic [SW_W-1:0] ledr,
    output logic            irq
);

    localparam int RAM_DEPTH = 1 << RAM_AW;

    logic [3:0]        region;
    logic [RAM_AW-1:0] ram_idx;
    logic [15:0]       ram [RAM_DEPTH];
    logic [15:0]       ram_rdata_p1;
    logic              rd_ram_p1;
    logic [15:0]       io_rdata;
    logic [15:0]       io_rdata_p1;
    logic [SW_W-1:0]   led_q;
    logic [SW_W-1:0]   sw_meta;
    logic [SW_W-1:0]   sw_sync;
    logic [15:0]       tmr_rdata;
    logic              unused_addr;

    assign region  = bus.addr[15:12];
    assign ram_idx = bus.addr[RAM_AW-1:0];

    // Address bits between the RAM index and the region code alias the RAM.
    assign unused_addr = ^bus.addr[11:RAM_AW];

    // RAM has no reset so it can map onto block memory; the non-blocking read
    // of the old word gives read-before-write on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (bus.w && region == REG_RAM) begin
            ram[ram_idx] <= bus.dout;
        end
        ram_rdata_p1 <= ram[ram_idx];
    end

`ifdef MEM_IO_TIMER_EN
    logic        tmr_load_we;
    logic        tmr_ctrl_we;
    logic [15:0] tmr_count;
    logic        tmr_en;
    logic        tmr_expired;

    assign tmr_load_we = bus.w && (region == REG_TMR) && (bus.addr[0] == TMR_LOAD);
    assign tmr_ctrl_we = bus.w && (region == REG_TMR) && (bus.addr[0] == TMR_CTRL);

    io_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load_we (tmr_load_we),
        .ctrl_we (tmr_ctrl_we),
        .wdata   (bus.dout),
        .count   (tmr_count),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    assign tmr_rdata = (bus.addr[0] == TMR_LOAD) ? tmr_count
                                                 : {14'b0, tmr_en, tmr_expired};
    assign irq = tmr_expired;
`else
    assign tmr_rdata = '0;
    assign irq       = 1'b0;
`endif

    always_comb begin
        io_rdata = '0;
        case (region)
            REG_LED: io_rdata[SW_W-1:0] = led_q;
            REG_SW:  io_rdata[SW_W-1:0] = sw_sync;
            REG_TMR: io_rdata = tmr_rdata;
            default: io_rdata = '0;
        endcase
    end

    // Read stage boundary: rd_ram_p1 resets low so reset forces din to 0 and
    // drops any read that was in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ram_p1   <= 1'b0;
            io_rdata_p1 <= '0;
            led_q       <= '0;
            sw_meta     <= '0;
            sw_sync     <= '0;
        end else begin
            rd_ram_p1   <= (region == REG_RAM);
            io_rdata_p1 <= io_rdata;
            sw_meta     <= sw;
            sw_sync     <= sw_meta;
            if (bus.w && region == REG_LED) begin
                led_q <= bus.dout[SW_W-1:0];
            end
        end
    end

    assign bus.din = rd_ram_p1 ? ram_rdata_p1 : io_rdata_p1;
    assign ledr    = led_q;

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

    localparam int RAM_AW   = 8;
    localparam int SW_W     = 10;
    localparam int PRESCALE = 2;

    logic            clk;
    logic            reset_n;
    logic [SW_W-1:0] sw;
    logic [SW_W-1:0] ledr;
    logic            irq;

    int vectors;
    int miscompares;

    mem_io_if bus_if ();

    mem_io_responder #(
        .RAM_AW   (RAM_AW),
        .SW_W     (SW_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if),
        .sw      (sw),
        .ledr    (ledr),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: drive, take the rising edge, settle 1 time unit after it.
    task automatic op(input logic [15:0] a, input logic [15:0] d, input logic we);
        bus_if.addr = a;
        bus_if.dout = d;
        bus_if.w    = we;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus_if.din !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_din got=%h want=%h", bus_if.din, 16'h0000);
        end
        vectors++;
        if (ledr !== 10'h000) begin
            miscompares++;
            $display("FAIL reset_ledr got=%h want=%h", ledr, 10'h000);
        end
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_irq got=%b want=0", irq);
        end
        reset_n = 1'b1;
        op(16'h2001, 16'h0000, 1'b0);
        op(16'h2000, 16'h0000, 1'b0);
        vectors++;
        if (bus_if.din !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_tmr_status got=%h want=%h", bus_if.din, 16'h0000);
        end
    endtask

    task automatic test_ram();
        op(16'h0005, 16'h1234, 1'b1);
        op(16'h0005, 16'h0000, 1'b0);
        vectors++;
        if (bus_if.din !== 16'h1234) begin
            miscompares++;
            $display("FAIL ram_raw got=%h want=%h", bus_if.din, 16'h1234);
        end
        op(16'h0005, 16'hBEEF, 1'b1);
        vectors++;
        if (bus_if.din !== 16'h1234) begin
            miscompares++;
            $display("FAIL ram_rbw got=%h want=%h", bus_if.din, 16'h1234);
        end
        op(16'h0005, 16'h0000, 1'b0);
        vectors++;
        if (bus_if.din !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL ram_after_rbw got=%h want=%h", bus_if.din, 16'hBEEF);
        end
    endtask

    task automatic test_led_sw();
        op(16'h1000, 16'h03FF, 1'b1);
        vectors++;
        if (ledr !== 10'h3FF) begin
            miscompares++;
            $display("FAIL led_write got=%h want=%h", ledr, 10'h3FF);
        end
        op(16'h1000, 16'h0000, 1'b0);
        vectors++;
        if (bus_if.din !== 16'h03FF) begin
            miscompares++;
            $display("FAIL led_read got=%h want=%h", bus_if.din, 16'h03FF);
        end
        op(16'h3000, 16'h0155, 1'b1);
        vectors++;
        if (ledr !== 10'h3FF) begin
            miscompares++;
            $display("FAIL sw_write_ignored ledr got=%h want=%h", ledr, 10'h3FF);
        end
        sw = 10'h155;
        op(16'h3000, 16'h0000, 1'b0);
        vectors++;
        if (bus_if.din !== 16'h0000) begin
            miscompares++;
            $display("FAIL sw_edge1 got=%h want=%h", bus_if.din, 16'h0000);
        end
        op(16'h3000, 16'h0000, 1'b0);
        vectors++;
        if (bus_if.din !== 16'h0000) begin
            miscompares++;
            $display("FAIL sw_edge2 got=%h want=%h", bus_if.din, 16'h0000);
        end
        op(16'h3000, 16'h0000, 1'b0);
        vectors++;
        if (bus_if.din !== 16'h0155) begin
            miscompares++;
            $display("FAIL sw_edge3 got=%h want=%h", bus_if.din, 16'h0155);
        end
    endtask

    task automatic test_alias_unmapped();
        op(16'h0105, 16'h00AA, 1'b1);
        op(16'h0005, 16'h0000, 1'b0);
        vectors++;
        if (bus_if.din !== 16'h00AA) begin
            miscompares++;
            $display("FAIL ram_alias got=%h want=%h", bus_if.din, 16'h00AA);
        end
        op(16'h7005, 16'h0000, 1'b1);
        vectors++;
        if (ledr !== 10'h3FF) begin
            miscompares++;
            $display("FAIL unmapped_led got=%h want=%h", ledr, 10'h3FF);
        end
        op(16'h7005, 16'h0000, 1'b0);
        vectors++;
        if (bus_if.din !== 16'h0000) begin
            miscompares++;
            $display("FAIL unmapped_read got=%h want=%h", bus_if.din, 16'h0000);
        end
        op(16'h0005, 16'h0000, 1'b0);
        vectors++;
        if (bus_if.din !== 16'h00AA) begin
            miscompares++;
            $display("FAIL unmapped_ram got=%h want=%h", bus_if.din, 16'h00AA);
        end
    endtask

`ifdef MEM_IO_TIMER_EN
    task automatic test_timer();
        logic [15:0] exp_cnt [9];
        logic        exp_irq [9];
        exp_cnt = '{16'd3, 16'd3, 16'd2, 16'd2, 16'd1, 16'd1, 16'd0, 16'd0, 16'd3};
        exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        op(16'h2000, 16'h0003, 1'b1);
        op(16'h2001, 16'h0002, 1'b1);
        for (int i = 0; i < 9; i++) begin
            op(16'h2000, 16'h0000, 1'b0);
            vectors++;
            if (bus_if.din !== exp_cnt[i] || irq !== exp_irq[i]) begin
                miscompares++;
                $display("FAIL tmr_count[%0d] got cnt=%h irq=%b want cnt=%h irq=%b",
                         i, bus_if.din, irq, exp_cnt[i], exp_irq[i]);
            end
        end
        // Clear on a plain tick (count 3 -> 2), en kept.
        op(16'h2001, 16'h0003, 1'b1);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL tmr_clear got=%b want=0", irq);
        end
        op(16'h2001, 16'h0000, 1'b0);
        vectors++;
        if (bus_if.din !== 16'h0002) begin
            miscompares++;
            $display("FAIL tmr_status got=%h want=%h", bus_if.din, 16'h0002);
        end
        // LOAD=0 lands on a tick; next tick is an expiry.
        op(16'h2000, 16'h0000, 1'b1);
        op(16'h2000, 16'h0000, 1'b0);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL tmr_pre_expiry got=%b want=0", irq);
        end
        op(16'h2001, 16'h0003, 1'b1);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL tmr_clear_vs_expiry got=%b want=1", irq);
        end
        op(16'h2000, 16'h0000, 1'b0);
        op(16'h2000, 16'h0009, 1'b1);
        op(16'h2000, 16'h0000, 1'b0);
        vectors++;
        if (bus_if.din !== 16'h0009) begin
            miscompares++;
            $display("FAIL tmr_load_vs_tick got=%h want=%h", bus_if.din, 16'h0009);
        end
    endtask
`else
    task automatic test_timer();
        op(16'h2000, 16'h0003, 1'b1);
        op(16'h2005, 16'h0003, 1'b1);
        op(16'h2000, 16'h0000, 1'b0);
        vectors++;
        if (bus_if.din !== 16'h0000) begin
            miscompares++;
            $display("FAIL tmr_off_load got=%h want=%h", bus_if.din, 16'h0000);
        end
        op(16'h2001, 16'h0000, 1'b0);
        vectors++;
        if (bus_if.din !== 16'h0000 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL tmr_off_status got=%h irq=%b want=0000 irq=0", bus_if.din, irq);
        end
        op(16'h0005, 16'h0000, 1'b0);
        vectors++;
        if (bus_if.din !== 16'h00AA) begin
            miscompares++;
            $display("FAIL tmr_off_ram got=%h want=%h", bus_if.din, 16'h00AA);
        end
    endtask
`endif

    task automatic test_reset_mid_op();
        op(16'h1000, 16'h02AA, 1'b1);
        op(16'h1000, 16'h0000, 1'b0);
        vectors++;
        if (bus_if.din !== 16'h02AA) begin
            miscompares++;
            $display("FAIL pre_reset_led got=%h want=%h", bus_if.din, 16'h02AA);
        end
        bus_if.addr = 16'h2000;
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (ledr !== 10'h000 || bus_if.din !== 16'h0000 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset got ledr=%h din=%h irq=%b want 000/0000/0",
                     ledr, bus_if.din, irq);
        end
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        op(16'h2000, 16'h0000, 1'b0);
        vectors++;
        if (bus_if.din !== 16'h0000) begin
            miscompares++;
            $display("FAIL post_reset_count got=%h want=%h", bus_if.din, 16'h0000);
        end
        op(16'h0005, 16'h0000, 1'b0);
        vectors++;
        if (bus_if.din !== 16'h00AA) begin
            miscompares++;
            $display("FAIL post_reset_ram got=%h want=%h", bus_if.din, 16'h00AA);
        end
        vectors++;
        if (ledr !== 10'h000 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_io got ledr=%h irq=%b want 000/0", ledr, irq);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        sw          = '0;
        bus_if.addr = '0;
        bus_if.dout = '0;
        bus_if.w    = 1'b0;
        test_reset();
        test_ram();
        test_led_sw();
        test_alias_unmapped();
        test_timer();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Bus responder on the processor's memory port. It answers the address, data-out and write-enable driven by the processor's control FSM.
- Serves instruction fetches and LD data from on-chip RAM with one cycle of synchronous read latency, and accepts ST writes.
- Provides three memory-mapped peripherals: an LED output register, a synchronized switch input and a down-counting timer.
- Sits between the processor top level and the board I/O.

Parameters:
- RAM_AW, 8, RAM word-address width; RAM depth is 2**RAM_AW 16-bit words.
- SW_W, 10, width of the switch input and LED output.
- PRESCALE, 50000, clock cycles per timer tick; minimum legal value is 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- addr  input  16  word address from the processor ADDR register.
- dout  input  16  write data from the processor DOUT register.
- w  input  1  write enable, active high, sampled on the rising clock edge.
- din  output  16  read data to the processor; valid one cycle after addr is presented.
- sw  input  SW_W  raw, asynchronous board switches.
- ledr  output  SW_W  LED register.
- irq  output  1  timer expired flag; level, sticky.

Behaviour:
- Decode on addr[15:12]:
  - 0x0: RAM, indexed by addr[RAM_AW-1:0]; addr bits above RAM_AW-1 in this region are ignored, so the RAM aliases.
  - 0x1: LED.
  - 0x2: timer.
  - 0x3: switches.
  - Any other region: reads return 0 and writes are ignored.
- Read path:
  - din is registered: din at edge N+1 reflects the addr applied before edge N+1.
  - Latency is exactly 1 cycle for every region.
  - A read and a write to the same RAM word in the same cycle is read-before-write: din returns the old data.
- RAM:
  - Written when w=1 and region is 0x0.
  - Contents are not cleared by reset.
- LED:
  - Written with w=1 at 0x1xxx: ledr <= dout[SW_W-1:0].
  - A read returns {0, ledr}.
- Switches:
  - Two-flop synchronizer; a read returns {0, sw_sync}.
  - A change on sw is visible on din no earlier than 3 edges later.
  - Writes are ignored.
- Timer (region 0x2):
  - Offset addr[0]=0 is LOAD/COUNT:
    - Writing sets reload=dout and count=dout, and clears the prescaler.
    - Reading returns the current count.
  - Offset addr[0]=1 is CTRL/STATUS:
    - Write: bit1 sets en; bit0 written as 1 clears expired.
    - Read: {14'b0, en, expired}.
  - When en=1, the prescaler counts 0..PRESCALE-1; on its terminal value, count decrements.
  - When count=0 at a tick: count <= reload and expired <= 1.
  - A reload value of 0 gives expiry on every tick.
  - When en=0: the prescaler and count hold.
  - Same cycle as an expiry tick:
    - A clear write loses; expired stays 1.
    - A LOAD write wins over the decrement and reload.
  - irq = expired.
- Reset, asynchronous and also when asserted mid-operation:
  - din=0, ledr=0, reload=0, count=0, prescaler=0, en=0, expired=0.
  - Synchronizer flops = 0.
  - An in-flight read is discarded.
  - Operation resumes on the first edge after reset_n rises.
- No handshake or back-pressure: every access completes with fixed latency, matching the processor's fixed T-state timing.

Optional Feature:
- Macro: MEM_IO_TIMER_EN.
- Defined: the timer exists as described above.
- Undefined: no timer logic is generated; region 0x2 reads return 0, writes are ignored, and irq is tied to 0.
- The port list is identical in both builds.

Decomposition:
- Package mem_map_pkg:
  - Region codes: REG_RAM=4'h0, REG_LED=4'h1, REG_TMR=4'h2, REG_SW=4'h3.
  - Timer offsets: TMR_LOAD=1'b0, TMR_CTRL=1'b1.
  - CTRL bit indices: BIT_CLR=0, BIT_EN=1.
- One sub-module, io_timer: prescaler, count, reload, en and expired. It takes its write strobes and read data from the parent's decode and is instantiated only under MEM_IO_TIMER_EN.

Test Plan:
- RAM read-after-write: write 0x1234 to 0x0005, then apply addr 0x0005 -> din=0x1234 one edge later. Same-cycle read and write of 0xBEEF to 0x0005 -> din=0x1234.
- Aliasing and unmapped regions: write 0x00AA to 0x0105 with RAM_AW=8 -> a read of 0x0005 returns 0x00AA. Write to 0x7000, then read 0x7000 -> din=0x0000, and no RAM or LED change.
- LED/switch: write 0x03FF to 0x1000 -> ledr=10'h3FF. Set sw=10'h155 -> a read of 0x3000 returns 0x0155 within 3 edges, never earlier.
- Timer with PRESCALE=2: write LOAD=3, then CTRL=0x2 -> count reads 3, 2, 1, 0. irq rises on the tick after count 0, and count returns to 3. Writing CTRL=0x3 clears irq and keeps en=1.
- Simultaneous events: a clear write coincident with an expiry tick -> irq stays 1. A LOAD=9 write coincident with a tick -> count=9 next cycle.
- Asynchronous reset mid-count: drop reset_n between edges -> ledr, din, irq and count are 0 immediately. Previously written RAM data reads back intact after release.
